// File: rtl/insn_buffer.sv
// insn_buffer: fetch-to-decode decoupling queue of halfword entries.
// Reassembles RVC and 32-bit instructions (including ones split across
// fetch words and across the queue wrap point) and presents one per cycle.
// Optional zero-latency bypass when empty: define RAFI_INSN_BUFFER_BYPASS_EN.
module insn_buffer #(
    parameter int unsigned ENTRY_COUNT  = 4,
    parameter logic [31:0] INITIAL_PC_P = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        flush,
    input  logic        fetchValid,
    output logic        fetchReady,
    input  logic [31:0] fetchPc,
    input  logic [31:0] fetchWord,
    input  logic        fetchFault,
    output logic        insnValid,
    input  logic        insnReady,
    output logic [31:0] insnPc,
    output logic [31:0] insnWord,
    output logic        insnFault
);

    localparam int unsigned PTR_W = $clog2(ENTRY_COUNT);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned HW_W  = 16;

    // Halfword storage; contents are only meaningful where count covers them.
    logic [31:0]     pc_q    [ENTRY_COUNT];
    logic            fault_q [ENTRY_COUNT];
    logic [HW_W-1:0] insn_q  [ENTRY_COUNT];

    logic [PTR_W-1:0] read_ptr_q;
    logic [PTR_W-1:0] write_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] write_ptr1;
    logic [31:0]      head_pc;
    logic             head_fault;
    logic [HW_W-1:0]  head_insn;
    logic             next_fault;
    logic [HW_W-1:0]  next_insn;
    logic             has_any;
    logic             has_two;
    logic [1:0]       need;
    logic             push;
    logic             pop;
    logic [1:0]       n_wr;
    logic [1:0]       rd_adv;
    logic [31:0]      wr0_pc;
    logic [HW_W-1:0]  wr0_insn;
    logic [31:0]      wr1_pc;
    logic [HW_W-1:0]  wr1_insn;
`ifdef RAFI_INSN_BUFFER_BYPASS_EN
    logic             bypass;
`endif

    assign next_ptr   = read_ptr_q + PTR_W'(1);
    assign write_ptr1 = write_ptr_q + PTR_W'(1);

    // Room for a full aligned fetch word, judged on registered occupancy only.
    assign fetchReady = (count_q <= CNT_W'(ENTRY_COUNT - 2));

    // Select the head pair, optionally taken straight from the fetch port.
    always_comb begin
        head_pc    = pc_q[read_ptr_q];
        head_fault = fault_q[read_ptr_q];
        head_insn  = insn_q[read_ptr_q];
        next_fault = fault_q[next_ptr];
        next_insn  = insn_q[next_ptr];
        has_any    = (count_q != '0);
        has_two    = (count_q >= CNT_W'(2));
`ifdef RAFI_INSN_BUFFER_BYPASS_EN
        bypass     = (count_q == '0) && fetchValid && !flush;
        if (bypass) begin
            head_pc    = fetchPc;
            head_fault = fetchFault;
            head_insn  = fetchPc[1] ? fetchWord[31:16] : fetchWord[15:0];
            next_fault = fetchFault;
            next_insn  = fetchWord[31:16];
            has_any    = 1'b1;
            has_two    = !fetchPc[1];
        end
`endif
    end

    // Head decode: fault, RVC, or 32-bit instruction needing two halfwords.
    always_comb begin
        insnValid = 1'b0;
        insnFault = 1'b0;
        insnWord  = '0;
        insnPc    = INITIAL_PC_P;
        need      = 2'd1;
        if (has_any) begin
            insnPc = head_pc;
            if (head_fault) begin
                insnValid = 1'b1;
                insnFault = 1'b1;
            end else if (head_insn[1:0] != 2'b11) begin
                insnValid = 1'b1;
                insnWord  = {16'h0, head_insn};
            end else begin
                need = 2'd2;
                if (has_two) begin
                    insnValid = 1'b1;
                    insnWord  = {next_insn, head_insn};
                    insnFault = next_fault;
                end
            end
        end
    end

    assign push = fetchValid && fetchReady && !flush;
    assign pop  = insnValid && insnReady && !flush;

    // Work out which halfwords get written and how far the read side moves.
    always_comb begin
        n_wr     = 2'd0;
        rd_adv   = pop ? need : 2'd0;
        wr0_pc   = fetchPc;
        wr0_insn = fetchPc[1] ? fetchWord[31:16] : fetchWord[15:0];
        wr1_pc   = fetchPc + 32'd2;
        wr1_insn = fetchWord[31:16];
        if (push) begin
            n_wr = fetchPc[1] ? 2'd1 : 2'd2;
        end
`ifdef RAFI_INSN_BUFFER_BYPASS_EN
        // Bypassed and consumed: nothing left in storage to pop, store leftover only.
        if (bypass && pop) begin
            rd_adv = 2'd0;
            if (!fetchPc[1] && (need == 2'd1)) begin
                n_wr     = 2'd1;
                wr0_pc   = fetchPc + 32'd2;
                wr0_insn = fetchWord[31:16];
            end else begin
                n_wr = 2'd0;
            end
        end
`endif
    end

    // Pointer and occupancy state; flush dominates any push or pop.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            read_ptr_q  <= '0;
            write_ptr_q <= '0;
            count_q     <= '0;
        end else if (flush) begin
            read_ptr_q  <= '0;
            write_ptr_q <= '0;
            count_q     <= '0;
        end else begin
            read_ptr_q  <= read_ptr_q + PTR_W'(rd_adv);
            write_ptr_q <= write_ptr_q + PTR_W'(n_wr);
            count_q     <= count_q + CNT_W'(n_wr) - CNT_W'(rd_adv);
        end
    end

    // Entry writes; the fetch fault tags every halfword written.
    always_ff @(posedge clk) begin
        if (n_wr != 2'd0) begin
            pc_q[write_ptr_q]    <= wr0_pc;
            fault_q[write_ptr_q] <= fetchFault;
            insn_q[write_ptr_q]  <= wr0_insn;
        end
        if (n_wr == 2'd2) begin
            pc_q[write_ptr1]    <= wr1_pc;
            fault_q[write_ptr1] <= fetchFault;
            insn_q[write_ptr1]  <= wr1_insn;
        end
    end

endmodule

// File: tb/tb_insn_buffer.sv
// tb_insn_buffer: directed scenarios plus random traffic against a
// queue-of-halfwords reference model of the instruction buffer.
module tb_insn_buffer;

    localparam int unsigned N   = 4;
    localparam logic [31:0] IPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        flush = 1'b0;
    logic        fetchValid = 1'b0;
    logic        fetchReady;
    logic [31:0] fetchPc = IPC;
    logic [31:0] fetchWord = '0;
    logic        fetchFault = 1'b0;
    logic        insnValid;
    logic        insnReady = 1'b0;
    logic [31:0] insnPc;
    logic [31:0] insnWord;
    logic        insnFault;

    insn_buffer #(.ENTRY_COUNT(N), .INITIAL_PC_P(IPC)) dut (
        .clk(clk), .rstN(rstN), .flush(flush),
        .fetchValid(fetchValid), .fetchReady(fetchReady), .fetchPc(fetchPc),
        .fetchWord(fetchWord), .fetchFault(fetchFault),
        .insnValid(insnValid), .insnReady(insnReady), .insnPc(insnPc),
        .insnWord(insnWord), .insnFault(insnFault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        fault;
        logic [15:0] insn;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic        e_valid, e_fault, e_ready;
    logic [31:0] e_pc, e_word;
    int          e_need;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs straight from the instruction-assembly rules on the queue.
    task automatic model_out();
        e_ready = (q.size() <= int'(N) - 2);
        e_valid = 1'b0; e_fault = 1'b0; e_word = '0; e_pc = IPC; e_need = 1;
        if (q.size() > 0) begin
            e_pc = q[0].pc;
            if (q[0].fault) begin
                e_valid = 1'b1; e_fault = 1'b1;
            end else if (q[0].insn[1:0] != 2'b11) begin
                e_valid = 1'b1; e_word = {16'h0, q[0].insn};
            end else begin
                e_need = 2;
                if (q.size() >= 2) begin
                    e_valid = 1'b1;
                    e_word  = {q[1].insn, q[0].insn};
                    e_fault = q[1].fault;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        model_out();
        chk({tag, ".fetchReady"}, 32'(fetchReady), 32'(e_ready));
        chk({tag, ".insnValid"}, 32'(insnValid), 32'(e_valid));
        chk({tag, ".insnPc"}, insnPc, e_pc);
        if (e_valid) begin
            chk({tag, ".insnWord"}, insnWord, e_word);
            chk({tag, ".insnFault"}, 32'(insnFault), 32'(e_fault));
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] w,
                        input logic ff, input logic rdy, input logic fl, output logic pushed);
        logic do_push, do_pop;
        int   need;
        fetchValid = fv; fetchPc = pc; fetchWord = w; fetchFault = ff;
        insnReady = rdy; flush = fl;
        #1;
        check_outputs("step");
        do_push = fv && e_ready && !fl;
        do_pop  = e_valid && rdy && !fl;
        need    = e_need;
        pushed  = do_push;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) repeat (need) void'(q.pop_front());
            if (do_push) begin
                if (pc[1]) begin
                    q.push_back('{pc: pc, fault: ff, insn: w[31:16]});
                end else begin
                    q.push_back('{pc: pc, fault: ff, insn: w[15:0]});
                    q.push_back('{pc: pc + 32'd2, fault: ff, insn: w[31:16]});
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        logic p;
        step(1'b0, IPC, 32'h0, 1'b0, rdy, 1'b0, p);
    endtask

    initial begin
        logic        p;
        logic [31:0] spc;

        #1;
        chk("reset.insnValid", 32'(insnValid), 32'd0);
        chk("reset.insnPc", insnPc, IPC);
        chk("reset.insnWord", insnWord, 32'h0);
        chk("reset.insnFault", 32'(insnFault), 32'd0);
        chk("reset.fetchReady", 32'(fetchReady), 32'd1);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Aligned RVC pair
        step(1'b1, 32'h8000_0000, 32'h0001_4505, 1'b0, 1'b0, 1'b0, p);
        chk("rvc0.word", insnWord, 32'h0000_4505);
        chk("rvc0.pc", insnPc, 32'h8000_0000);
        idle(1'b1);
        chk("rvc1.word", insnWord, 32'h0000_0001);
        chk("rvc1.pc", insnPc, 32'h8000_0002);
        idle(1'b1);
        chk("rvc.empty", 32'(insnValid), 32'd0);

        // Aligned 32-bit
        step(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0, p);
        chk("i32.valid", 32'(insnValid), 32'd1);
        chk("i32.word", insnWord, 32'h0000_0013);
        idle(1'b1);
        chk("i32.empty", 32'(insnValid), 32'd0);

        // Split 32-bit across fetch words
        step(1'b1, 32'h8000_0002, 32'h0293_0000, 1'b0, 1'b0, 1'b0, p);
        chk("split.wait", 32'(insnValid), 32'd0);
        step(1'b1, 32'h8000_0004, 32'hFFFF_0010, 1'b0, 1'b0, 1'b0, p);
        chk("split.word", insnWord, 32'h0010_0293);
        chk("split.pc", insnPc, 32'h8000_0002);
        idle(1'b1);
        idle(1'b0);
        step(1'b0, IPC, 32'h0, 1'b0, 1'b0, 1'b1, p);

        // Faulted fetch
        step(1'b1, 32'h8000_0008, 32'h1234_5678, 1'b1, 1'b0, 1'b0, p);
        chk("fault.flag", 32'(insnFault), 32'd1);
        chk("fault.word", insnWord, 32'h0);
        chk("fault.pc", insnPc, 32'h8000_0008);
        idle(1'b1);
        idle(1'b1);

        // Backpressure to full, then drain one entry at a time
        step(1'b1, 32'h8000_0000, 32'h0001_4505, 1'b0, 1'b0, 1'b0, p);
        step(1'b1, 32'h8000_0004, 32'h0002_4509, 1'b0, 1'b0, 1'b0, p);
        chk("full.ready", 32'(fetchReady), 32'd0);
        idle(1'b0);
        chk("full.hold", insnWord, 32'h0000_4505);
        idle(1'b1);
        chk("full.free1", 32'(fetchReady), 32'd0);
        idle(1'b1);
        chk("full.free2", 32'(fetchReady), 32'd1);

        // Flush with a concurrent push and pop at count=3
        step(1'b1, 32'h8000_000A, 32'h0003_0000, 1'b0, 1'b0, 1'b0, p);
        step(1'b1, 32'h8000_0010, 32'h0005_0007, 1'b0, 1'b1, 1'b1, p);
        chk("flush.valid", 32'(insnValid), 32'd0);
        chk("flush.pc", insnPc, IPC);

        // Random traffic with occasional redirects
        spc = 32'h8000_0000;
        for (int i = 0; i < 600; i++) begin
            logic fl;
            fl = ($urandom_range(0, 99) < 3);
            step(($urandom_range(0, 99) < 70), spc, $urandom, ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 60), fl, p);
            if (fl)     spc = 32'h8000_0000 + ($urandom & 32'h0000_0FFE);
            else if (p) spc = (spc & ~32'h3) + 32'd4;
        end

        // Asynchronous reset mid-stream
        step(1'b1, 32'h8000_0100, 32'h0001_4505, 1'b0, 1'b0, 1'b0, p);
        #2;
        rstN = 1'b0;
        #1;
        q.delete();
        chk("arst.insnValid", 32'(insnValid), 32'd0);
        chk("arst.insnPc", insnPc, IPC);
        chk("arst.insnWord", insnWord, 32'h0);
        chk("arst.insnFault", 32'(insnFault), 32'd0);
        chk("arst.fetchReady", 32'(fetchReady), 32'd1);
        @(negedge clk);
        rstN = 1'b1;
        step(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0, p);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insn_buffer.md
Name: insn_buffer

Overview:
- Fetch-to-decode decoupling stage: accepts 32-bit aligned fetch words and stores them as halfword entries (pc, fault, 16-bit insn) in a circular queue.
- Reassembles RVC (16-bit) and full 32-bit instructions, including 32-bit instructions split across fetch words, and presents one instruction per cycle to decode.
- Sits between the fetch unit and the decode stage. Flushed on redirect or trap.

Parameters:
- ENTRY_COUNT, default INSN_BUFFER_ENTRY_COUNT (4): number of halfword entries. Must be a power of two, ≥4.
- INITIAL_PC_P, default INITIAL_PC (32'h80000000): value driven on insnPc while the buffer is empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstN  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries this cycle
- fetchValid  in  1  fetch word offered
- fetchReady  out  1  buffer accepts fetch word
- fetchPc  in  32  pc of fetch; bit 0 always 0
- fetchWord  in  32  fetched word; [15:0] = halfword at pc&~3, [31:16] = halfword at (pc&~3)+2
- fetchFault  in  1  fetch access fault
- insnValid  out  1  assembled instruction available
- insnReady  in  1  decode consumes instruction
- insnPc  out  32  pc of instruction
- insnWord  out  32  instruction; RVC is zero-extended to 32
- insnFault  out  1  fault on any constituent halfword

Behaviour:
- Reset (rstN=0, asynchronous): readPtr=0, writePtr=0, count=0. Outputs: insnValid=0, insnPc=INITIAL_PC_P, insnWord=0, insnFault=0, fetchReady=1.
- Storage: ENTRY_COUNT entries of {pc, fault, insn[15:0]}.
  - Pointers are $clog2(ENTRY_COUNT) bits and wrap modulo ENTRY_COUNT.
  - count is $clog2(ENTRY_COUNT)+1 bits.
- Push:
  - Push occurs when fetchValid && fetchReady && !flush.
  - fetchPc[1]=0: two entries are written in order ({pc, [15:0]}, then {pc+2, [31:16]}); count += 2.
  - fetchPc[1]=1: one entry {pc, [31:16]} is written; count += 1.
  - fetchFault is copied into every entry written.
- fetchReady = (ENTRY_COUNT − count ≥ 2), evaluated on registered count only. It does not depend on a same-cycle pop and has no combinational path from insnReady.
- Head decode (combinational from registered state), with head = entry[readPtr] and next = entry[readPtr+1]:
  - count=0: insnValid=0.
  - head.fault=1: insnValid=1, insnFault=1, insnWord=0, need=1.
  - head.insn[1:0]≠2'b11: RVC. insnValid=1, insnWord={16'h0, head.insn}, insnFault=0, need=1.
  - Otherwise (32-bit instruction):
    - Valid only if count ≥ 2; insnWord={next.insn, head.insn}; insnFault=next.fault; need=2.
    - count=1 → insnValid=0 and the instruction waits for the next push.
  - insnPc=head.pc whenever count>0, otherwise INITIAL_PC_P.
- Pop: occurs when insnValid && insnReady && !flush; readPtr += need; count −= need.
- Simultaneous push and pop: count_next = count + pushed − need. Both pointers update independently.
- Latency: a fetch word pushed in cycle N is visible at the outputs in cycle N+1.
- Flush:
  - Pointers and count reset to 0 at the next edge.
  - Any push or pop in the same cycle is ignored; flush dominates.
  - fetchReady stays unchanged in the flush cycle; it is based on registered count.
- Outputs are stable while insnValid=1 and insnReady=0.
- Wrap-around: a 32-bit instruction whose halves sit in entry ENTRY_COUNT−1 and entry 0 assembles correctly.
- Never overflow (guaranteed by fetchReady). Never underflow (pop requires insnValid).

Optional Feature:
- Macro RAFI_INSN_BUFFER_BYPASS_EN.
- Defined:
  - When count=0, fetchValid=1 and !flush, the head decode uses the incoming fetch halfwords directly, giving zero-cycle latency.
  - If decode pops in that cycle, the consumed halfwords are not written; only any leftover halfword is stored.
  - A 32-bit instruction needing 2 halfwords with fetchPc[1]=1 is not bypassed; it is stored.
  - This adds a combinational path fetch→insn, but none from insnReady to fetchReady.
- Undefined: no bypass; minimum latency 1 cycle as specified above.

Test Plan:
- Aligned RVC pair: push pc=0x80000000, word=0x00014505 (two RVC halfwords) → next cycle insnWord=0x00004505 @0x80000000, then 0x00000001 @0x80000002; count returns to 0.
- Aligned 32-bit: push pc=0x80000000, word=0x00000013 → next cycle insnValid=1, insnWord=0x00000013, insnPc=0x80000000; pop consumes 2 entries.
- Split 32-bit instruction:
  - Push pc=0x80000002, word=0x02930000 (only halfword 0x0293 is stored) → insnValid=0 while count=1.
  - Push pc=0x80000004, word=0xFFFF0010 → insnWord=0x00100293 @0x80000002.
- Fault: push pc=0x80000008 with fetchFault=1 → insnValid=1, insnFault=1, insnWord=0, insnPc=0x80000008.
- Backpressure and full:
  - Hold insnReady=0 and push 2 aligned words → count=4, fetchReady=0.
  - Outputs hold stable; after one pop of an RVC entry, fetchReady stays 0 (free=1); after a second pop, fetchReady=1.
- Flush and reset: with count=3, assert flush together with fetchValid=1 → next cycle count=0, insnValid=0, insnPc=0x80000000. Pulse rstN low mid-stream → outputs return immediately to reset values.
